fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage pipeline; feeds the decode stage (register file side).
//   Holds the PC, the word-addressed instruction memory and the IF/ID pipeline register.
//   A synchronous load port writes program images directly, so benches do not need hierarchical $readmemh.
//   Stall, branch redirect and flush commands come from the hazard/execute logic.
// PARAMETERS
//   DATA_WIDTH       32    instruction and PC width
//   INSTR_MEM_DEPTH  32    instruction memory depth in words (power of 2)
//   RESET_PC         0     PC value after reset (word aligned)
//   NOP_INSTR        32'h0 encoding inserted on bubble or flush
// PORTS
//   CLK            in   1            rising-edge clock
//   RST            in   1            asynchronous, active-low reset
//   LD_EN          in   1            write LD_DATA to memory word LD_ADDR; freezes fetch
//   LD_ADDR        in   log2(DEPTH)  word index for the load
//   LD_DATA        in   DATA_WIDTH   instruction word to load
//   STALL          in   1            hold the PC and IF/ID (load-use hazard)
//   PC_SRC         in   1            redirect the PC to BRANCH_TARGET and flush IF/ID
//   BRANCH_TARGET  in   DATA_WIDTH   byte address of the redirect
//   IF_ID_INSTR    out  DATA_WIDTH   registered instruction
//   IF_ID_PC       out  DATA_WIDTH   registered PC of that instruction
//   IF_ID_PC4      out  DATA_WIDTH   registered PC+4
//   IF_ID_VALID    out  1            1 = real instruction, 0 = bubble
// BEHAVIOUR
//   Reset (RST=0, asynchronous, also mid-run):
//     - PC = RESET_PC, IF_ID_INSTR = NOP_INSTR, IF_ID_PC = 0, IF_ID_PC4 = 0, IF_ID_VALID = 0.
//     - Memory contents are not reset.
//   Memory:
//     - Read is combinational at index PC[log2(DEPTH)+1:2]; upper PC bits are ignored, so the index wraps modulo DEPTH.
//     - Write is synchronous on CLK when LD_EN=1.
//   Per-edge priority (highest first):
//     1 LD_EN=1  : PC holds; IF/ID becomes a bubble (NOP_INSTR, VALID=0).
//     2 PC_SRC=1 : PC <= {BRANCH_TARGET[31:2],2'b00}; IF/ID becomes a bubble. PC_SRC wins over STALL.
//     3 STALL=1  : PC and all IF_ID_* hold their values.
//     4 else     : IF_ID_INSTR <= mem[PC], IF_ID_PC <= PC, IF_ID_PC4 <= PC+4, VALID <= 1, PC <= PC+4.
//   Latency: the word at PC appears on IF_ID_* one edge after it is addressed.
//   Arithmetic: PC+4 is modulo 2^DATA_WIDTH, so 32'hFFFFFFFC+4 = 0. No exceptions are raised.
//   A stall asserted for N cycles holds IF/ID for exactly N edges, and no instruction is lost or duplicated.
//   When LD_EN deasserts, fetch resumes from the held PC on the next edge.
// STRUCTURE
//   Shared package pipe_pkg:
//     - DATA_WIDTH, NOP_INSTR, RESET_PC
//     - IF/ID bundle typedef {instr, pc, pc4, valid}, reused by decode_stage
//   Sub-module instr_mem:
//     - DEPTH x DATA_WIDTH array, async read, sync write
//     - mem array name kept as "mem"
//   The PC register and the IF/ID register are in this module.
// TESTING
//   1 Load mem[0..3] = 11,22,33,44 via LD_EN, then release LD_EN
//     -> IF_ID_INSTR = 11,22,33,44 on successive edges, IF_ID_PC = 0,4,8,12, VALID=1.
//   2 STALL=1 for 2 cycles while IF_ID_PC=4
//     -> IF_ID_* unchanged for 2 edges, then IF_ID_PC=8 (no skip, no repeat).
//   3 PC_SRC=1, BRANCH_TARGET=0x0C, with STALL=1 in the same cycle
//     -> next edge VALID=0 and INSTR=NOP; following edge IF_ID_PC=0x0C, INSTR=mem[3].
//   4 BRANCH_TARGET=0x7E (misaligned, DEPTH 32)
//     -> PC=0x7C, fetch index 31; the next fetch wraps to index 0 (PC=0x80).
//   5 Assert RST low asynchronously mid-cycle during a run
//     -> outputs clear immediately without waiting for CLK; after release, fetch restarts at RESET_PC; memory is intact.
//   6 LD_EN pulse during a run
//     -> one bubble per LD_EN cycle; PC held; the loaded word is fetched when its address is reached.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core.
// Holds the datapath width, the reset PC and the bubble encoding, plus the
// IF/ID bundle type that the fetch stage produces and decode_stage consumes.
// No ports: package only.
package pipe_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  // One IF/ID pipeline slot: the fetched word, where it came from and the
  // sequential successor address. A cleared valid marks a bubble.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc4;
    logic                  valid;
  } if_id_t;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory for the fetch stage.
// Read is combinational so the addressed word is available in the same cycle
// as the PC; write is synchronous and is used to load program images.
// Contents are deliberately never reset.
// Ports:
//   clk        in   rising-edge clock for writes
//   wr_en      in   write wr_data into word wr_addr on the clock edge
//   wr_addr    in   word index of the write
//   wr_data    in   word to write
//   rd_addr    in   word index of the read
//   rd_data    out  word at rd_addr (combinational)
module instr_mem #(
  parameter int unsigned DATA_WIDTH = pipe_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Synchronous load port; no reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage pipeline.
// Owns the PC, the instruction memory and the IF/ID pipeline register that
// feeds decode. Loads, branch redirects and load-use stalls are applied with
// a fixed priority: load, then redirect, then stall, then normal fetch.
// Ports:
//   CLK            in   rising-edge clock
//   RST            in   asynchronous active-low reset
//   LD_EN          in   write LD_DATA to word LD_ADDR; freezes fetch
//   LD_ADDR        in   word index for the load
//   LD_DATA        in   instruction word to load
//   STALL          in   hold PC and IF/ID
//   PC_SRC         in   redirect PC to BRANCH_TARGET and flush IF/ID
//   BRANCH_TARGET  in   byte address of the redirect
//   IF_ID_INSTR    out  registered instruction
//   IF_ID_PC       out  registered PC of that instruction
//   IF_ID_PC4      out  registered PC+4
//   IF_ID_VALID    out  1 = real instruction, 0 = bubble
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = pipe_pkg::DATA_WIDTH,
  parameter int unsigned           INSTR_MEM_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = pipe_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR       = pipe_pkg::NOP_INSTR,
  parameter int unsigned           AW              = $clog2(INSTR_MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD_EN,
  input  logic [AW-1:0]         LD_ADDR,
  input  logic [DATA_WIDTH-1:0] LD_DATA,
  input  logic                  STALL,
  input  logic                  PC_SRC,
  input  logic [DATA_WIDTH-1:0] BRANCH_TARGET,
  output logic [DATA_WIDTH-1:0] IF_ID_INSTR,
  output logic [DATA_WIDTH-1:0] IF_ID_PC,
  output logic [DATA_WIDTH-1:0] IF_ID_PC4,
  output logic                  IF_ID_VALID
);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target_aligned;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic [AW-1:0]         fetch_index;

  // Only the word-index bits of the PC address memory, so fetches past the
  // end of the array wrap back to word 0.
  assign fetch_index    = pc[AW+1:2];
  assign pc_plus4       = pc + DATA_WIDTH'(4);
  assign target_aligned = BRANCH_TARGET & ~DATA_WIDTH'(3);

  instr_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (INSTR_MEM_DEPTH),
    .AW         (AW)
  ) u_instr_mem (
    .clk     (CLK),
    .wr_en   (LD_EN),
    .wr_addr (LD_ADDR),
    .wr_data (LD_DATA),
    .rd_addr (fetch_index),
    .rd_data (fetch_word)
  );

  // PC and IF/ID update. A load freezes the PC and emits bubbles so that a
  // half-written program is never fetched; a redirect beats a stall because
  // the stalled instruction sits on the wrong path and must be flushed.
  // On a bubble the PC fields keep their last value; only the instruction
  // and valid flag carry meaning.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc          <= RESET_PC;
      IF_ID_INSTR <= NOP_INSTR;
      IF_ID_PC    <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_VALID <= 1'b0;
    end else if (LD_EN) begin
      IF_ID_INSTR <= NOP_INSTR;
      IF_ID_VALID <= 1'b0;
    end else if (PC_SRC) begin
      pc          <= target_aligned;
      IF_ID_INSTR <= NOP_INSTR;
      IF_ID_VALID <= 1'b0;
    end else if (!STALL) begin
      pc          <= pc_plus4;
      IF_ID_INSTR <= fetch_word;
      IF_ID_PC    <= pc;
      IF_ID_PC4   <= pc_plus4;
      IF_ID_VALID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Each task drives one scenario and checks the IF/ID register against
// hand-computed values; the expected memory image is kept in exp_mem.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        LD_EN;
  logic [4:0]  LD_ADDR;
  logic [31:0] LD_DATA;
  logic        STALL;
  logic        PC_SRC;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_VALID;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [32];
  logic [96:0] got;
  logic [96:0] exp;

  fetch_stage dut (
    .CLK           (CLK),
    .RST           (RST),
    .LD_EN         (LD_EN),
    .LD_ADDR       (LD_ADDR),
    .LD_DATA       (LD_DATA),
    .STALL         (STALL),
    .PC_SRC        (PC_SRC),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IF_ID_INSTR   (IF_ID_INSTR),
    .IF_ID_PC      (IF_ID_PC),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_VALID   (IF_ID_VALID)
  );

  // Free-running 10-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Backstop so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Compare a full IF/ID slot.
  task automatic expect_slot(input string name, input logic [31:0] instr,
                             input logic [31:0] pc, input logic valid);
    got = {IF_ID_INSTR, IF_ID_PC, IF_ID_PC4, IF_ID_VALID};
    exp = {instr, pc, pc + 32'd4, valid};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got instr=%h pc=%h pc4=%h v=%b want instr=%h pc=%h pc4=%h v=%b",
               name, IF_ID_INSTR, IF_ID_PC, IF_ID_PC4, IF_ID_VALID,
               instr, pc, pc + 32'd4, valid);
    end
  endtask

  // Compare a bubble: only the instruction and valid flag are defined.
  task automatic expect_bubble(input string name);
    checks++;
    if ({IF_ID_INSTR, IF_ID_VALID} !== {32'h0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s: got instr=%h v=%b want instr=00000000 v=0",
               name, IF_ID_INSTR, IF_ID_VALID);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; LD_EN = 1'b0; LD_ADDR = '0; LD_DATA = '0;
    STALL = 1'b0; PC_SRC = 1'b0; BRANCH_TARGET = '0;
    step();
    got = {IF_ID_INSTR, IF_ID_PC, IF_ID_PC4, IF_ID_VALID};
    checks++;
    if (got !== 97'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got instr=%h pc=%h pc4=%h v=%b want all zero",
               IF_ID_INSTR, IF_ID_PC, IF_ID_PC4, IF_ID_VALID);
    end
    RST = 1'b1;
  endtask

  task automatic test_load();
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = (i < 4) ? 32'(i + 1) * 32'h11 : 32'hA000_0000 + 32'(i);
      LD_EN = 1'b1; LD_ADDR = 5'(i); LD_DATA = exp_mem[i];
      step();
    end
    expect_bubble("load_bubble");
    LD_EN = 1'b0;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) begin
      step();
      expect_slot($sformatf("fetch_seq%0d", i), exp_mem[i], 32'(i * 4), 1'b1);
    end
  endtask

  task automatic test_stall();
    PC_SRC = 1'b1; BRANCH_TARGET = 32'h4;
    step();
    expect_bubble("stall_redirect_bubble");
    PC_SRC = 1'b0;
    step();
    expect_slot("stall_pre", 32'h22, 32'h4, 1'b1);
    STALL = 1'b1;
    step();
    expect_slot("stall_hold1", 32'h22, 32'h4, 1'b1);
    step();
    expect_slot("stall_hold2", 32'h22, 32'h4, 1'b1);
    STALL = 1'b0;
    step();
    expect_slot("stall_resume", 32'h33, 32'h8, 1'b1);
    step();
    expect_slot("stall_next", 32'h44, 32'hC, 1'b1);
  endtask

  task automatic test_branch_over_stall();
    PC_SRC = 1'b1; STALL = 1'b1; BRANCH_TARGET = 32'h0C;
    step();
    expect_bubble("branch_stall_bubble");
    PC_SRC = 1'b0; STALL = 1'b0;
    step();
    expect_slot("branch_stall_target", exp_mem[3], 32'h0C, 1'b1);
  endtask

  task automatic test_misaligned();
    PC_SRC = 1'b1; BRANCH_TARGET = 32'h7E;
    step();
    expect_bubble("misaligned_bubble");
    PC_SRC = 1'b0;
    step();
    expect_slot("misaligned_target", exp_mem[31], 32'h7C, 1'b1);
    step();
    expect_slot("index_wrap", exp_mem[0], 32'h80, 1'b1);
  endtask

  task automatic test_pc_wrap();
    PC_SRC = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    step();
    PC_SRC = 1'b0;
    step();
    expect_slot("pc_top", exp_mem[31], 32'hFFFF_FFFC, 1'b1);
    step();
    expect_slot("pc_wrap_zero", exp_mem[0], 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    step();
    #3 RST = 1'b0;
    #1;
    got = {IF_ID_INSTR, IF_ID_PC, IF_ID_PC4, IF_ID_VALID};
    checks++;
    if (got !== 97'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got instr=%h pc=%h pc4=%h v=%b want all zero",
               IF_ID_INSTR, IF_ID_PC, IF_ID_PC4, IF_ID_VALID);
    end
    step();
    RST = 1'b1;
    step();
    expect_slot("reset_restart0", exp_mem[0], 32'h0, 1'b1);
    step();
    expect_slot("reset_restart1", exp_mem[1], 32'h4, 1'b1);
  endtask

  task automatic test_load_pulse();
    LD_EN = 1'b1; LD_ADDR = 5'd3; LD_DATA = 32'h55;
    exp_mem[3] = 32'h55;
    step();
    expect_bubble("load_pulse_bubble1");
    LD_ADDR = 5'd5; LD_DATA = 32'h66;
    exp_mem[5] = 32'h66;
    step();
    expect_bubble("load_pulse_bubble2");
    LD_EN = 1'b0;
    step();
    expect_slot("load_pulse_resume", exp_mem[2], 32'h8, 1'b1);
    step();
    expect_slot("load_pulse_new3", 32'h55, 32'hC, 1'b1);
    step();
    expect_slot("load_pulse_old4", exp_mem[4], 32'h10, 1'b1);
    step();
    expect_slot("load_pulse_new5", 32'h66, 32'h14, 1'b1);
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_stall();
    test_branch_over_stall();
    test_misaligned();
    test_pc_wrap();
    test_async_reset();
    test_load_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
